// File: rtl/bus_arbiter_n_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_n_if
//
// Bundles the request, slave-ready, split and grant signals of the ADS system
// bus arbiter. Clock and reset are not part of the bundle.
//
// Signals (NUM_MASTERS = N, MW = max(1, clog2(N))):
//   breq          [N]   bus request, bit i = master i
//   sready_nsplit [1]   AND of all non-split slaves' ready
//   sreadysp      [1]   split-capable slave ready
//   ssplit        [1]   split-capable slave holds a split pending
//   bgrant        [N]   one-hot grant, zero when idle
//   msel          [MW]  index of the granted master, zero when idle
//   msplit        [N]   bit i high while master i owns the pending split
//   split_grant   [1]   one-cycle pulse when a split is handed back
//
// Modports:
//   master : the arbiter itself (drives grants, samples requests)
//   slave  : the requester/slave side (drives requests, samples grants)
// -----------------------------------------------------------------------------
interface bus_arbiter_n_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] breq;
    logic                   sready_nsplit;
    logic                   sreadysp;
    logic                   ssplit;
    logic [NUM_MASTERS-1:0] bgrant;
    logic [MW-1:0]          msel;
    logic [NUM_MASTERS-1:0] msplit;
    logic                   split_grant;

    modport master (
        input  breq,
        input  sready_nsplit,
        input  sreadysp,
        input  ssplit,
        output bgrant,
        output msel,
        output msplit,
        output split_grant
    );

    modport slave (
        output breq,
        output sready_nsplit,
        output sreadysp,
        output ssplit,
        input  bgrant,
        input  msel,
        input  msplit,
        input  split_grant
    );
endinterface

// File: rtl/bus_arbiter_n.sv
// -----------------------------------------------------------------------------
// bus_arbiter_n
//
// N-master arbiter for the ADS system bus. Grants the shared bus to one
// requester at a time using fixed priority (index 0 highest) or round-robin,
// optionally preempting an owner that has held the bus for MAX_HOLD cycles
// while another master waits. One split transaction on the split-capable slave
// may be outstanding; while it is pending other masters may use the bus, and
// when the slave drops ssplit the bus is handed back to the split owner.
//
// Parameters:
//   NUM_MASTERS  number of masters, 2..8
//   RR_MODE      0 = fixed priority, 1 = round-robin
//   MAX_HOLD     max consecutive grant cycles with a competitor waiting,
//                0 = unlimited
//
// Ports:
//   clk   in   bus clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   if   bus_arbiter_n_if.master (requests, slave status, grants)
// -----------------------------------------------------------------------------
module bus_arbiter_n #(
    parameter int NUM_MASTERS = 4,
    parameter int RR_MODE     = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_n_if.master  bus
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    // Value at which the hold counter saturates; the grant may be taken away
    // when the counter sits here and a competitor is waiting.
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One-hot vector with bit idx set.
    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
        logic [NUM_MASTERS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Pointer following index w, wrapping at NUM_MASTERS (handles N that is
    // not a power of two).
    function automatic logic [MW-1:0] next_ptr(input logic [MW-1:0] w);
        logic [MW-1:0] nxt;
        if (w == MW'(NUM_MASTERS - 1)) begin
            nxt = '0;
        end else begin
            nxt = w + MW'(1);
        end
        return nxt;
    endfunction

    // Arbitration winner over req. Fixed priority picks the lowest set index;
    // round-robin scans from ptr upward, wrapping, and picks the first set one.
    // Returns 0 when req is empty (callers qualify with req != 0).
    function automatic logic [MW-1:0] arb_winner(
        input logic [NUM_MASTERS-1:0] req,
        input logic [MW-1:0]          ptr
    );
        logic [MW-1:0] win;
        logic          found;
        logic [MW:0]   idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE != 0) begin
                idx = {1'b0, ptr} + (MW+1)'(k);
                if (idx >= (MW+1)'(NUM_MASTERS)) begin
                    idx = idx - (MW+1)'(NUM_MASTERS);
                end else begin
                    idx = idx;
                end
            end else begin
                idx = (MW+1)'(k);
            end
            if (!found && req[idx[MW-1:0]]) begin
                win   = idx[MW-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]             state_q,       state_d;
    logic [MW-1:0]          owner_q,       owner_d;
    logic                   split_valid_q, split_valid_d;
    logic [MW-1:0]          split_owner_q, split_owner_d;
    logic [MW-1:0]          rr_ptr_q,      rr_ptr_d;
    logic [HW-1:0]          hold_cnt_q,    hold_cnt_d;
    logic [NUM_MASTERS-1:0] msplit_q,      msplit_d;
    logic                   split_grant_q, split_grant_d;

    logic [NUM_MASTERS-1:0] owner_mask_s;
    logic [NUM_MASTERS-1:0] split_mask_s;
    logic [NUM_MASTERS-1:0] arb_req_s;
    logic                   arb_ok_s;
    logic [MW-1:0]          win_s;
    logic [NUM_MASTERS-1:0] others_s;
    logic                   hold_expire_s;
    logic                   leave_s;

    // Decode owner / split owner into masks.
    always_comb begin
        owner_mask_s = onehot(owner_q);
        split_mask_s = onehot(split_owner_q);
    end

    // Requests eligible for arbitration out of IDLE and whether a new
    // arbitrated grant may start. While a split is pending only the
    // non-split slaves need to be ready, and the split owner is excluded
    // because it is waiting on the split slave, not on the bus.
    always_comb begin
        if (bus.ssplit) begin
            if (split_valid_q) begin
                arb_req_s = bus.breq & ~split_mask_s;
            end else begin
                arb_req_s = '0;
            end
            arb_ok_s = split_valid_q && (arb_req_s != '0) && bus.sready_nsplit;
        end else begin
            arb_req_s = bus.breq;
            arb_ok_s  = !split_valid_q && (bus.breq != '0)
                        && bus.sready_nsplit && bus.sreadysp;
        end
        win_s = arb_winner(arb_req_s, rr_ptr_q);
    end

    // Conditions that end the current grant. A split owner masked out of
    // arbitration is not a competitor for the hold limit.
    always_comb begin
        if (split_valid_q && bus.ssplit) begin
            others_s = bus.breq & ~owner_mask_s & ~split_mask_s;
        end else begin
            others_s = bus.breq & ~owner_mask_s;
        end
        hold_expire_s = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && (others_s != '0);
        leave_s       = !bus.breq[owner_q] || (!split_valid_q && bus.ssplit) || hold_expire_s;
    end

    // Next-state logic: IDLE/GRANT sequencing, split capture and release.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        split_valid_d = split_valid_q;
        split_owner_d = split_owner_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        msplit_d      = msplit_q;
        split_grant_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (!bus.ssplit && split_valid_q) begin
                    // Split released: hand the bus back to its owner without
                    // disturbing the round-robin pointer.
                    state_d = ST_GRANT;
                    owner_d = split_owner_q;
                end else if (arb_ok_s) begin
                    state_d  = ST_GRANT;
                    owner_d  = win_s;
                    rr_ptr_d = next_ptr(win_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end

                if (!split_valid_q && bus.ssplit) begin
                    // Capture a new split for the current owner.
                    msplit_d      = msplit_q | owner_mask_s;
                    split_owner_d = owner_q;
                    split_valid_d = 1'b1;
                end else if (split_valid_q && (owner_q == split_owner_q) && !bus.ssplit) begin
                    // Owner is back on the bus with the split completed.
                    msplit_d      = msplit_q & ~owner_mask_s;
                    split_valid_d = 1'b0;
                    split_grant_d = 1'b1;
                end else begin
                    msplit_d = msplit_q;
                end

                if (leave_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            split_valid_q <= 1'b0;
            split_owner_q <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            msplit_q      <= '0;
            split_grant_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            split_valid_q <= split_valid_d;
            split_owner_q <= split_owner_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            msplit_q      <= msplit_d;
            split_grant_q <= split_grant_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        if (state_q == ST_GRANT) begin
            bus.bgrant = owner_mask_s;
            bus.msel   = owner_q;
        end else begin
            bus.bgrant = '0;
            bus.msel   = '0;
        end
        bus.msplit      = msplit_q;
        bus.split_grant = split_grant_q;
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_n
//
// Two arbiters share one stimulus stream: instance 0 is fixed priority with no
// hold limit, instance 1 is round-robin with a 4-cycle hold limit. Directed
// scenarios are followed by randomized traffic; every cycle both instances are
// compared against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_n;

    localparam int NM    = 4;
    localparam int FP_MH = 0;
    localparam int RR_MH = 4;

    logic clk;
    logic rst_v;
    logic [NM-1:0] breq_v;
    logic rdy_ns_v;
    logic rdy_sp_v;
    logic ss_v;

    int n_tests;
    int n_fail;

    bus_arbiter_n_if #(.NUM_MASTERS(NM)) fp_if ();
    bus_arbiter_n_if #(.NUM_MASTERS(NM)) rr_if ();

    assign fp_if.breq          = breq_v;
    assign fp_if.sready_nsplit = rdy_ns_v;
    assign fp_if.sreadysp      = rdy_sp_v;
    assign fp_if.ssplit        = ss_v;
    assign rr_if.breq          = breq_v;
    assign rr_if.sready_nsplit = rdy_ns_v;
    assign rr_if.sreadysp      = rdy_sp_v;
    assign rr_if.ssplit        = ss_v;

    bus_arbiter_n #(.NUM_MASTERS(NM), .RR_MODE(0), .MAX_HOLD(FP_MH)) dut_fp (
        .clk (clk),
        .rst (rst_v),
        .bus (fp_if)
    );

    bus_arbiter_n #(.NUM_MASTERS(NM), .RR_MODE(1), .MAX_HOLD(RR_MH)) dut_rr (
        .clk (clk),
        .rst (rst_v),
        .bus (rr_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model (index 0 = fp, 1 = rr) ---------------
    int          cfg_rr [2];
    int          cfg_mh [2];
    bit          m_busy [2];
    int          m_owner[2];
    bit          m_spv  [2];
    int          m_spo  [2];
    int          m_ptr  [2];
    int          m_held [2];
    bit          m_sg   [2];
    logic [NM-1:0] m_msplit[2];

    function automatic int pick(input logic [NM-1:0] req, input int rr, input int ptr);
        for (int k = 0; k < NM; k++) begin
            int i;
            i = rr ? (ptr + k) % NM : k;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        logic [NM-1:0] req;
        logic [NM-1:0] others;
        int  w;
        bit  leave;
        if (rst_v) begin
            m_busy[d] = 0; m_owner[d] = 0; m_spv[d] = 0; m_spo[d] = 0;
            m_ptr[d] = 0; m_held[d] = 0; m_sg[d] = 0; m_msplit[d] = '0;
        end else if (!m_busy[d]) begin
            w = -1;
            if (!ss_v) begin
                if (m_spv[d]) begin
                    m_busy[d] = 1; m_owner[d] = m_spo[d]; m_held[d] = 0;
                end else if (breq_v != 0 && rdy_ns_v && rdy_sp_v) begin
                    w = pick(breq_v, cfg_rr[d], m_ptr[d]);
                end
            end else if (m_spv[d] && rdy_ns_v) begin
                req = breq_v;
                req[m_spo[d]] = 1'b0;
                w = pick(req, cfg_rr[d], m_ptr[d]);
            end
            if (w >= 0) begin
                m_busy[d] = 1; m_owner[d] = w; m_held[d] = 0; m_ptr[d] = (w + 1) % NM;
            end
            m_sg[d] = 0;
        end else begin
            others = breq_v;
            others[m_owner[d]] = 1'b0;
            if (m_spv[d] && ss_v) others[m_spo[d]] = 1'b0;
            leave = !breq_v[m_owner[d]] || (!m_spv[d] && ss_v)
                    || (cfg_mh[d] != 0 && m_held[d] + 1 >= cfg_mh[d] && others != 0);
            m_sg[d] = 0;
            if (!m_spv[d] && ss_v) begin
                m_msplit[d][m_owner[d]] = 1'b1; m_spo[d] = m_owner[d]; m_spv[d] = 1;
            end else if (m_spv[d] && m_owner[d] == m_spo[d] && !ss_v) begin
                m_msplit[d][m_owner[d]] = 1'b0; m_spv[d] = 0; m_sg[d] = 1;
            end
            m_held[d]++;
            if (leave) m_busy[d] = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_dut(input int d, input logic [NM-1:0] g, input logic [1:0] ms,
                               input logic [NM-1:0] sp, input logic sg);
        logic [NM-1:0] exp_g;
        int            exp_ms;
        exp_g  = m_busy[d] ? (4'b0001 << m_owner[d]) : 4'b0000;
        exp_ms = m_busy[d] ? m_owner[d] : 0;
        check_val($sformatf("dut%0d.bgrant", d), 32'(g), 32'(exp_g));
        check_val($sformatf("dut%0d.msel", d), 32'(ms), 32'(exp_ms));
        check_val($sformatf("dut%0d.msplit", d), 32'(sp), 32'(m_msplit[d]));
        check_val($sformatf("dut%0d.split_grant", d), 32'(sg), 32'(m_sg[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_dut(0, fp_if.bgrant, fp_if.msel, fp_if.msplit, fp_if.split_grant);
        compare_dut(1, rr_if.bgrant, rr_if.msel, rr_if.msplit, rr_if.split_grant);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cfg_rr[0] = 0; cfg_mh[0] = FP_MH;
        cfg_rr[1] = 1; cfg_mh[1] = RR_MH;
        rst_v = 1'b1; breq_v = '0; rdy_ns_v = 1'b1; rdy_sp_v = 1'b1; ss_v = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("reset fp bgrant", 32'(fp_if.bgrant), 32'h0);
        check_val("reset rr msplit", 32'(rr_if.msplit), 32'h0);
        rst_v = 1'b0;

        // Fixed priority: 1010 -> master 1, then master 3 after one idle cycle
        breq_v = 4'b1010;
        tick();
        check_val("fp first grant", 32'(fp_if.bgrant), 32'h2);
        check_val("fp first msel", 32'(fp_if.msel), 32'h1);
        breq_v = 4'b1000;
        tick();
        check_val("fp idle gap", 32'(fp_if.bgrant), 32'h0);
        tick();
        check_val("fp second grant", 32'(fp_if.bgrant), 32'h8);
        check_val("fp second msel", 32'(fp_if.msel), 32'h3);
        breq_v = '0;
        tick();

        // Round-robin: order 0,1,2,3,0 with two grant cycles each
        for (int k = 0; k < 5; k++) begin
            logic [NM-1:0] want;
            want   = 4'b0001 << (k % NM);
            breq_v = 4'b1111;
            tick();
            check_val($sformatf("rr order %0d c1", k), 32'(rr_if.bgrant), 32'(want));
            tick();
            check_val($sformatf("rr order %0d c2", k), 32'(rr_if.bgrant), 32'(want));
            breq_v = 4'b1111 & ~want;
            tick();
            check_val($sformatf("rr order %0d gap", k), 32'(rr_if.bgrant), 32'h0);
        end
        breq_v = '0;
        tick();

        // Hold limit: master 0 keeps 4 cycles while master 2 waits
        breq_v = 4'b0001;
        tick();
        check_val("hold c1", 32'(rr_if.bgrant), 32'h1);
        breq_v = 4'b0101;
        for (int i = 2; i <= RR_MH; i++) begin
            tick();
            check_val($sformatf("hold c%0d", i), 32'(rr_if.bgrant), 32'h1);
        end
        tick();
        check_val("hold preempt gap", 32'(rr_if.bgrant), 32'h0);
        tick();
        check_val("hold next owner", 32'(rr_if.bgrant), 32'h4);
        breq_v = '0;
        tick();
        tick();

        // Split: master 1 splits, master 3 uses the bus, master 1 returns
        breq_v = 4'b0010;
        tick();
        check_val("split owner grant", 32'(rr_if.bgrant), 32'h2);
        ss_v = 1'b1;
        tick();
        check_val("split captured", 32'(rr_if.msplit), 32'h2);
        check_val("split idle", 32'(rr_if.bgrant), 32'h0);
        breq_v   = 4'b1000;
        rdy_sp_v = 1'b0;
        tick();
        check_val("split other grant", 32'(rr_if.bgrant), 32'h8);
        check_val("split other msel", 32'(rr_if.msel), 32'h3);
        tick();
        breq_v = 4'b0010; ss_v = 1'b0; rdy_sp_v = 1'b1;
        tick();
        check_val("split release idle", 32'(rr_if.bgrant), 32'h0);
        tick();
        check_val("split return grant", 32'(rr_if.bgrant), 32'h2);
        check_val("split msplit held", 32'(rr_if.msplit), 32'h2);
        tick();
        check_val("split_grant pulse", 32'(rr_if.split_grant), 32'h1);
        check_val("split msplit clear", 32'(rr_if.msplit), 32'h0);
        tick();
        check_val("split_grant single", 32'(rr_if.split_grant), 32'h0);
        breq_v = '0;
        tick();
        tick();

        // Not ready: no grant until the split slave is ready
        breq_v = 4'b0001; rdy_sp_v = 1'b0;
        tick();
        tick();
        check_val("not ready fp", 32'(fp_if.bgrant), 32'h0);
        rdy_sp_v = 1'b1;
        tick();
        check_val("ready fp", 32'(fp_if.bgrant), 32'h1);
        check_val("ready rr", 32'(rr_if.bgrant), 32'h1);
        breq_v = '0;
        tick();

        // Reset mid-split
        breq_v = 4'b0010;
        tick();
        ss_v = 1'b1;
        tick();
        breq_v = 4'b0100;
        tick();
        check_val("pre-reset grant", 32'(rr_if.bgrant), 32'h4);
        check_val("pre-reset msplit", 32'(rr_if.msplit), 32'h2);
        rst_v = 1'b1;
        tick();
        check_val("mid reset bgrant", 32'(rr_if.bgrant), 32'h0);
        check_val("mid reset msplit", 32'(rr_if.msplit), 32'h0);
        rst_v = 1'b0; ss_v = 1'b0; breq_v = 4'b0010;
        tick();
        check_val("post reset grant", 32'(rr_if.bgrant), 32'h2);
        check_val("post reset fp", 32'(fp_if.bgrant), 32'h2);
        breq_v = '0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 5) == 0) breq_v[i] = ~breq_v[i];
            end
            if ($urandom_range(0, 11) == 0) ss_v = ~ss_v;
            rdy_ns_v = ($urandom_range(0, 7) != 0);
            rdy_sp_v = ($urandom_range(0, 7) != 0);
            rst_v    = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
